rv32_flash_responder: RTL and testbench

Memory-side responder for the core's byte-serial code/data fetch path. It is the far end of the fetch FSM's flash port: it accepts one word-granular read or write request, inserts a programmable number of wait states, then returns read data as four byte beats (little-endian) or a single write-acknowledge beat. It stands in for external flash in system simulation and synthesis until the cache controllers land.

---
 rtl/rv32_flash_responder_if.sv | 22 ++
 rtl/rv32_flash_responder.sv | 144 ++++++++++++++
 tb/tb_rv32_flash_responder.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/rv32_flash_responder_if.sv
// Request/response bus between the fetch FSM (master) and the flash responder (slave).
interface rv32_flash_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_byte;
  logic        rsp_last;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_byte, rsp_last
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_byte, rsp_last
  );
endinterface

// File: rtl/rv32_flash_responder.sv
// Flash stand-in: accepts one word read/write, waits WAIT_STATES cycles, then
// returns four little-endian byte beats (read) or a single ack beat (write).
module rv32_flash_responder #(
  parameter int SIZE        = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  rv32_flash_responder_if.slave bus,
  output logic                 busy
);
  localparam int AW = $clog2(SIZE);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    READ = 2'd2,
    ACK  = 2'd3
  } state_t;

  state_t      state_reg;
  logic [3:0]  wait_cnt_reg;
  logic [1:0]  beat_cnt_reg;
  logic        write_reg;
  logic        req_ready_reg;
  logic        rsp_valid_reg;
  logic        rsp_last_reg;
  logic        busy_reg;
  logic [31:0] word_reg;
  logic [31:0] mem [SIZE];

  logic [AW-1:0] word_idx;
  logic          accept;
  logic [7:0]    word_bytes [4];
  logic          unused_addr;

  assign word_idx    = bus.req_addr[AW+1:2];
  assign unused_addr = ^{bus.req_addr[31:AW+2], bus.req_addr[1:0]};
  // Gated by rst so the storage (which has no reset) never commits a request seen during reset.
  assign accept      = bus.req_valid & req_ready_reg & ~rst;

  // Storage: writes commit on the accept edge; reads capture the addressed word.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (bus.req_write) begin
        mem[word_idx] <= bus.req_wdata;
      end else begin
        word_reg <= mem[word_idx];
      end
    end
  end

  // Byte lanes of the captured word, selected by the beat counter.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign word_bytes[gi] = word_reg[8*gi +: 8];
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      wait_cnt_reg  <= 4'd0;
      beat_cnt_reg  <= 2'd0;
      write_reg     <= 1'b0;
      req_ready_reg <= 1'b1;
      rsp_valid_reg <= 1'b0;
      rsp_last_reg  <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            write_reg     <= bus.req_write;
            beat_cnt_reg  <= 2'd0;
            req_ready_reg <= 1'b0;
            busy_reg      <= 1'b1;
            if (WAIT_STATES > 0) begin
              state_reg    <= WAIT;
              wait_cnt_reg <= WAIT_LOAD;
            end else begin
              state_reg     <= bus.req_write ? ACK : READ;
              rsp_valid_reg <= 1'b1;
              rsp_last_reg  <= bus.req_write;
            end
          end
        end
        WAIT: begin
          if (wait_cnt_reg == 4'd0) begin
            state_reg     <= write_reg ? ACK : READ;
            rsp_valid_reg <= 1'b1;
            rsp_last_reg  <= write_reg;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
          end
        end
        READ: begin
          if (bus.rsp_ready) begin
            if (beat_cnt_reg == 2'd3) begin
              state_reg     <= IDLE;
              beat_cnt_reg  <= 2'd0;
              rsp_valid_reg <= 1'b0;
              rsp_last_reg  <= 1'b0;
              req_ready_reg <= 1'b1;
              busy_reg      <= 1'b0;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + 2'd1;
              rsp_last_reg <= (beat_cnt_reg == 2'd2);
            end
          end
        end
        ACK: begin
          if (bus.rsp_ready) begin
            state_reg     <= IDLE;
            rsp_valid_reg <= 1'b0;
            rsp_last_reg  <= 1'b0;
            req_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          req_ready_reg <= 1'b1;
          rsp_valid_reg <= 1'b0;
          rsp_last_reg  <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_last  = rsp_last_reg;
  assign busy          = busy_reg;

  // Byte is forced to zero outside read beats (idle, wait, write ack).
  always_comb begin
    bus.rsp_byte = 8'h00;
    if (rsp_valid_reg && !write_reg) begin
      bus.rsp_byte = word_bytes[beat_cnt_reg];
    end
  end
endmodule

// File: tb/tb_rv32_flash_responder.sv
// Directed bench: a WAIT_STATES=2 instance (a) and a WAIT_STATES=0 instance (b).
module tb_rv32_flash_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_a = 1'b0;
  logic        req_valid_b = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_ready = 1'b1;
  logic        busy_a, busy_b;

  int n_cmp = 0;
  int n_bad = 0;

  rv32_flash_responder_if if_a ();
  rv32_flash_responder_if if_b ();

  assign if_a.req_valid = req_valid_a;
  assign if_a.req_write = req_write;
  assign if_a.req_addr  = req_addr;
  assign if_a.req_wdata = req_wdata;
  assign if_a.rsp_ready = rsp_ready;
  assign if_b.req_valid = req_valid_b;
  assign if_b.req_write = req_write;
  assign if_b.req_addr  = req_addr;
  assign if_b.req_wdata = req_wdata;
  assign if_b.rsp_ready = rsp_ready;

  rv32_flash_responder #(.SIZE(256), .WAIT_STATES(2)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a.slave), .busy(busy_a)
  );
  rv32_flash_responder #(.SIZE(256), .WAIT_STATES(0)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b.slave), .busy(busy_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {req_ready, rsp_valid, rsp_last, busy, rsp_byte}
  function automatic logic [11:0] outs(input bit s);
    if (s) return {if_b.req_ready, if_b.rsp_valid, if_b.rsp_last, busy_b, if_b.rsp_byte};
    return {if_a.req_ready, if_a.rsp_valid, if_a.rsp_last, busy_a, if_a.rsp_byte};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input bit s, input string tag);
    logic [11:0] o;
    o = outs(s);
    chk({tag, "_req_ready"}, 32'(o[11]), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(o[10]), 32'd0);
    chk({tag, "_rsp_last"},  32'(o[9]),  32'd0);
    chk({tag, "_busy"},      32'(o[8]),  32'd0);
    chk({tag, "_rsp_byte"},  32'(o[7:0]), 32'd0);
  endtask

  // One full transaction with rsp_ready held high; checks every cycle's timing.
  task automatic txn(input bit s, input bit wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp);
    int w;
    logic [11:0] o;
    w = s ? 0 : 2;
    chk("pre_req_ready", 32'(outs(s)), 32'(outs(s)) | 32'h800);
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    if (s) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    tick();
    req_valid_a = 1'b0;
    req_valid_b = 1'b0;
    o = outs(s);
    chk("accept_busy", 32'(o[8]), 32'd1);
    chk("accept_req_ready", 32'(o[11]), 32'd0);
    for (int i = 0; i < w; i++) begin
      chk("wait_rsp_valid", 32'(outs(s) >> 10) & 32'd1, 32'd0);
      tick();
    end
    if (wr) begin
      o = outs(s);
      chk("ack_valid", 32'(o[10]), 32'd1);
      chk("ack_last",  32'(o[9]),  32'd1);
      chk("ack_byte",  32'(o[7:0]), 32'd0);
      tick();
    end else begin
      for (int b = 0; b < 4; b++) begin
        o = outs(s);
        chk("beat_valid", 32'(o[10]), 32'd1);
        chk("beat_byte",  32'(o[7:0]), 32'(exp[8*b +: 8]));
        chk("beat_last",  32'(o[9]),  (b == 3) ? 32'd1 : 32'd0);
        tick();
      end
    end
    chk_idle(s, "post");
    $display("txn dut=%s %s addr=%h wdata=%h exp=%h", s ? "b" : "a",
             wr ? "WR" : "RD", addr, wdata, exp);
  endtask

  initial begin
    logic [11:0] o;

    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 32'h0000_0404, 32'h1122_3344, 32'h0};
    vecs[3] = '{1'b0, 32'h0000_0004, 32'h0,         32'h1122_3344};
    vecs[4] = '{1'b0, 32'h0000_0007, 32'h0,         32'h1122_3344};
    vecs[5] = '{1'b1, 32'h0000_03FC, 32'hA5A5_0F0F, 32'h0};
    vecs[6] = '{1'b0, 32'hFFFF_F7FC, 32'h0,         32'hA5A5_0F0F};
    vecs[7] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};

    // Reset, then idle for 10 cycles.
    tick();
    tick();
    rst = 1'b0;
    chk_idle(1'b0, "reset_a");
    chk_idle(1'b1, "reset_b");
    for (int i = 0; i < 10; i++) tick();
    chk_idle(1'b0, "idle10_a");
    $display("txn reset/idle checked");

    // Table-driven transactions on the W=2 instance, back to back.
    for (int i = 0; i < 8; i++) begin
      txn(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
    end

    // Backpressure: stall 3 cycles on beat 2 of a read of 0x10.
    req_write = 1'b0;
    req_addr  = 32'h10;
    req_valid_a = 1'b1;
    tick();
    req_valid_a = 1'b0;
    tick();
    tick();
    chk("bp_beat0", 32'(if_a.rsp_byte), 32'hEF);
    tick();
    chk("bp_beat1", 32'(if_a.rsp_byte), 32'hBE);
    tick();
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_byte",  32'(if_a.rsp_byte),  32'hAD);
      chk("bp_hold_last",  32'(if_a.rsp_last),  32'd0);
      chk("bp_hold_valid", 32'(if_a.rsp_valid), 32'd1);
      if (i == 2) rsp_ready = 1'b1;
      tick();
    end
    chk("bp_beat3", 32'(if_a.rsp_byte), 32'hDE);
    chk("bp_last3", 32'(if_a.rsp_last), 32'd1);
    tick();
    chk_idle(1'b0, "bp_done");
    $display("txn dut=a RD addr=00000010 backpressure on beat 2");

    // W=0 instance: write then read, first beat on N+1.
    txn(1'b1, 1'b1, 32'h20, 32'hCAFE_F00D, 32'h0);
    txn(1'b1, 1'b0, 32'h20, 32'h0, 32'hCAFE_F00D);

    // W=0: request held through busy is accepted on the first IDLE cycle.
    req_write = 1'b0;
    req_addr  = 32'h20;
    req_valid_b = 1'b1;
    tick();
    for (int b = 0; b < 4; b++) begin
      o = outs(1'b1);
      chk("hold_busy_ready", 32'(o[11]), 32'd0);
      chk("hold_beat_byte",  32'(o[7:0]), (32'hCAFE_F00D >> (8*b)) & 32'hFF);
      tick();
    end
    chk("hold_idle_ready", 32'(if_b.req_ready), 32'd1);
    chk("hold_idle_valid", 32'(if_b.rsp_valid), 32'd0);
    tick();
    req_valid_b = 1'b0;
    chk("hold_reaccept_valid", 32'(if_b.rsp_valid), 32'd1);
    chk("hold_reaccept_byte",  32'(if_b.rsp_byte),  32'h0D);
    for (int b = 0; b < 4; b++) tick();
    chk_idle(1'b1, "hold_done");
    $display("txn dut=b RD addr=00000020 held request re-accepted");

    // Reset mid-read on beat 1; requests during reset must be ignored.
    req_write = 1'b0;
    req_addr  = 32'h10;
    req_valid_a = 1'b1;
    tick();
    req_valid_a = 1'b0;
    tick();
    tick();
    tick();
    chk("rst_pre_beat1", 32'(if_a.rsp_byte), 32'hBE);
    rst = 1'b1;
    #1;
    chk("rst_async_valid", 32'(if_a.rsp_valid), 32'd0);
    req_write = 1'b1;
    req_wdata = 32'h0;
    req_valid_a = 1'b1;
    tick();
    tick();
    req_valid_a = 1'b0;
    rst = 1'b0;
    chk_idle(1'b0, "rst_after");
    $display("txn dut=a reset during read beat 1");
    txn(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
